// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - opcode constants, format codes and XLEN check for the immediate stage
package imm_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_FENCE    = 7'b0001111;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational instruction-to-immediate decoder
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  generate
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("imm_extract: XLEN must be 32 or 64");
    end
  endgenerate

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        fmt = FMT_I;
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_OPIMM: begin
        if (is_shift) begin
          fmt = FMT_SHAMT;
          if (XLEN == 64) imm = {{(XLEN-6){1'b0}}, instr[25:20]};
          else            imm = {{(XLEN-5){1'b0}}, instr[24:20]};
        end else begin
          fmt = FMT_I;
          imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end
      end
      OP_OPIMM32: begin
        // word-sized ops only exist on RV64
        if (XLEN != 64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          fmt = FMT_SHAMT;
          imm = {{(XLEN-5){1'b0}}, instr[24:20]};
        end else begin
          fmt = FMT_I;
          imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        end
      end
      OP_STORE: begin
        fmt = FMT_S;
        imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt = FMT_B;
        imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt = FMT_U;
        imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt = FMT_J;
        imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          fmt = FMT_ZIMM;
          imm = {{(XLEN-5){1'b0}}, instr[19:15]};
        end
      end
      OP_OP, OP_OP32, OP_FENCE: begin
        fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate-generation stage with 2-entry skid buffer
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  logic             prim_valid;
  logic [XLEN-1:0]  prim_imm;
  fmt_e             prim_fmt;
  logic             prim_ill;
  logic [TAG_W-1:0] prim_tag;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  fmt_e             skid_fmt;
  logic             skid_ill;
  logic [TAG_W-1:0] skid_tag;

  logic accept;
  logic prim_free;

  assign accept    = in_valid && in_ready;
  assign prim_free = !prim_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prim_valid <= 1'b0;
      prim_imm   <= '0;
      prim_fmt   <= FMT_NONE;
      prim_ill   <= 1'b0;
      prim_tag   <= '0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_NONE;
      skid_ill   <= 1'b0;
      skid_tag   <= '0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      prim_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (prim_free) begin
      // in_ready is low whenever the skid holds data, so no accept can race the refill
      if (skid_valid) begin
        prim_valid <= 1'b1;
        prim_imm   <= skid_imm;
        prim_fmt   <= skid_fmt;
        prim_ill   <= skid_ill;
        prim_tag   <= skid_tag;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else begin
        prim_valid <= accept;
        if (accept) begin
          prim_imm <= dec_imm;
          prim_fmt <= dec_fmt;
          prim_ill <= dec_ill;
          prim_tag <= in_tag;
        end
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_fmt   <= dec_fmt;
      skid_ill   <= dec_ill;
      skid_tag   <= in_tag;
      in_ready   <= 1'b0;
    end
  end

  assign out_valid   = prim_valid;
  assign out_imm     = prim_imm;
  assign out_fmt     = prim_fmt;
  assign out_illegal = prim_ill;
  assign out_tag     = prim_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed self-checking bench for imm_gen_stage (XLEN 32 and 64)
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_in_tag, a_out_tag, a_out_imm;
  logic [2:0]  a_out_fmt;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_in_tag, b_out_tag;
  logic [63:0] b_out_imm;
  logic [2:0]  b_out_fmt;

  int tests = 0;
  int fails = 0;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_tag(a_out_tag)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_tag(b_out_tag)
  );

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_in_instr = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_instr = '0; b_in_tag = '0; b_out_ready = 1'b1;
    #1;
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL reset a_out_valid: got %b expected 0", a_out_valid); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL reset a_in_ready: got %b expected 1", a_in_ready); end
    tests++; if ({a_out_imm, a_out_fmt, a_out_illegal, a_out_tag} !== '0) begin fails++; $display("FAIL reset a_out_data: got %h/%0d/%b/%h expected zeros", a_out_imm, a_out_fmt, a_out_illegal, a_out_tag); end
    tests++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_imm !== 64'd0) begin fails++; $display("FAIL reset b: got valid=%b ready=%b imm=%h expected 0/1/0", b_out_valid, b_in_ready, b_out_imm); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_formats32;
    logic [31:0] ins [10] = '{32'hFFF00093, 32'h00112623, 32'hFE000CE3, 32'h123452B7, 32'h001000EF,
                             32'h0000007F, 32'h00509093, 32'h300FD073, 32'h002081B3, 32'h0010809B};
    logic [31:0] ims [10] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFF8, 32'h12345000, 32'h00000800,
                             32'h0, 32'h5, 32'h1F, 32'h0, 32'h0};
    logic [2:0]  fms [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd6, 3'd7, 3'd0, 3'd0};
    logic        ils [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    a_out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++; if (a_out_valid !== 1'b1) begin fails++; $display("FAIL fmt32[%0d] valid: got %b expected 1", i-1, a_out_valid); end
        tests++; if (a_out_imm !== ims[i-1]) begin fails++; $display("FAIL fmt32[%0d] imm: got %h expected %h", i-1, a_out_imm, ims[i-1]); end
        tests++; if (a_out_fmt !== fms[i-1]) begin fails++; $display("FAIL fmt32[%0d] fmt: got %0d expected %0d", i-1, a_out_fmt, fms[i-1]); end
        tests++; if (a_out_illegal !== ils[i-1]) begin fails++; $display("FAIL fmt32[%0d] illegal: got %b expected %b", i-1, a_out_illegal, ils[i-1]); end
        tests++; if (a_out_tag !== 32'(i-1)) begin fails++; $display("FAIL fmt32[%0d] tag: got %h expected %h", i-1, a_out_tag, i-1); end
        tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL fmt32[%0d] in_ready: got %b expected 1", i-1, a_in_ready); end
      end
      if (i < 10) begin
        a_in_valid = 1'b1; a_in_instr = ins[i]; a_in_tag = 32'(i);
      end else begin
        a_in_valid = 1'b0;
      end
    end
    @(negedge clk);
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL fmt32 drain valid: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_formats64;
    logic [31:0] ins [4] = '{32'h800002B7, 32'h03F0D093, 32'h0010809B, 32'h0050909B};
    logic [63:0] ims [4] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h1, 64'h5};
    logic [2:0]  fms [4] = '{3'd4, 3'd6, 3'd1, 3'd6};
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_instr = ins[i]; b_in_tag = 32'(100 + i);
      @(negedge clk);
      b_in_valid = 1'b0;
      tests++; if (b_out_valid !== 1'b1) begin fails++; $display("FAIL fmt64[%0d] valid: got %b expected 1", i, b_out_valid); end
      tests++; if (b_out_imm !== ims[i]) begin fails++; $display("FAIL fmt64[%0d] imm: got %h expected %h", i, b_out_imm, ims[i]); end
      tests++; if (b_out_fmt !== fms[i]) begin fails++; $display("FAIL fmt64[%0d] fmt: got %0d expected %0d", i, b_out_fmt, fms[i]); end
      tests++; if (b_out_illegal !== 1'b0) begin fails++; $display("FAIL fmt64[%0d] illegal: got %b expected 0", i, b_out_illegal); end
      tests++; if (b_out_tag !== 32'(100 + i)) begin fails++; $display("FAIL fmt64[%0d] tag: got %h expected %h", i, b_out_tag, 100 + i); end
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'hFFF00093; a_in_tag = 32'd1;
    @(negedge clk);
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp after first accept in_ready: got %b expected 1", a_in_ready); end
    a_in_tag = 32'd2;
    @(negedge clk);
    tests++; if (a_in_ready !== 1'b0) begin fails++; $display("FAIL bp after second accept in_ready: got %b expected 0", a_in_ready); end
    tests++; if (a_out_valid !== 1'b1 || a_out_tag !== 32'd1) begin fails++; $display("FAIL bp head: got valid=%b tag=%0d expected 1/1", a_out_valid, a_out_tag); end
    a_in_tag = 32'd3;
    @(negedge clk);
    tests++; if (a_in_ready !== 1'b0 || a_out_tag !== 32'd1) begin fails++; $display("FAIL bp hold: got ready=%b tag=%0d expected 0/1", a_in_ready, a_out_tag); end
    a_out_ready = 1'b1;
    @(negedge clk);
    tests++; if (a_out_valid !== 1'b1 || a_out_tag !== 32'd2) begin fails++; $display("FAIL bp order 2: got valid=%b tag=%0d expected 1/2", a_out_valid, a_out_tag); end
    tests++; if (a_in_ready !== 1'b1) begin fails++; $display("FAIL bp reopen in_ready: got %b expected 1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 1'b0;
    tests++; if (a_out_valid !== 1'b1 || a_out_tag !== 32'd3) begin fails++; $display("FAIL bp order 3: got valid=%b tag=%0d expected 1/3", a_out_valid, a_out_tag); end
    @(negedge clk);
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL bp empty: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_flush;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'h00112623; a_in_tag = 32'd10;
    @(negedge clk);
    a_in_tag = 32'd11;
    @(negedge clk);
    a_in_tag = 32'd12;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; a_in_valid = 1'b0;
    tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL flush full: got valid=%b ready=%b expected 0/1", a_out_valid, a_in_ready); end
    a_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush full leak: got valid=%b tag=%0d expected 0", a_out_valid, a_out_tag); end
    // one entry held, flush with a live input that in_ready would otherwise accept
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_tag = 32'd13;
    @(negedge clk);
    a_in_tag = 32'd14; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL flush drop: got valid=%b ready=%b tag=%0d expected 0/1", a_out_valid, a_in_ready, a_out_tag); end
    @(negedge clk);
    tests++; if (a_out_valid !== 1'b0) begin fails++; $display("FAIL flush drop leak: got valid=%b tag=%0d expected 0", a_out_valid, a_out_tag); end
  endtask

  task automatic test_reset_midstream;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_instr = 32'hFE000CE3; a_in_tag = 32'h55;
    @(negedge clk);
    a_in_valid = 1'b0;
    tests++; if (a_out_valid !== 1'b1 || a_out_tag !== 32'h55) begin fails++; $display("FAIL rst pre: got valid=%b tag=%h expected 1/55", a_out_valid, a_out_tag); end
    #2 reset = 1'b1;
    #1;
    tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin fails++; $display("FAIL rst async ctl: got valid=%b ready=%b expected 0/1", a_out_valid, a_in_ready); end
    tests++; if ({a_out_imm, a_out_fmt, a_out_illegal, a_out_tag} !== '0) begin fails++; $display("FAIL rst async data: got %h/%0d/%b/%h expected zeros", a_out_imm, a_out_fmt, a_out_illegal, a_out_tag); end
    @(negedge clk);
    reset = 1'b0;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_instr = 32'h123452B7; a_in_tag = 32'h66;
    @(negedge clk);
    a_in_valid = 1'b0;
    tests++; if (a_out_valid !== 1'b1 || a_out_imm !== 32'h12345000 || a_out_tag !== 32'h66) begin fails++; $display("FAIL rst post push: got valid=%b imm=%h tag=%h expected 1/12345000/66", a_out_valid, a_out_imm, a_out_tag); end
  endtask

  initial begin
    test_reset();
    test_formats32();
    test_formats64();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Parametrised, registered immediate-generation stage for the RV32/RV64 decode pipeline. It accepts raw instruction words with a valid/ready handshake and decodes every base-ISA immediate format: I, S, B, U, J, shift-amount, and CSR zimm. It emits a sign- or zero-extended XLEN immediate with a format code and an illegal flag. A 2-entry skid buffer gives full throughput under back-pressure and supports pipeline flush. It sits between fetch/IF-ID and the register-read/ALU operand mux.

## Interface
Parameters:
- XLEN, 32, immediate width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (PC) carried alongside each instruction.

Ports:
- clk  in  1  the only clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  decoded entry present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code: NONE=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, ZIMM=7.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the entry shown on out_*.

## Operation
Opcode decode on instr[6:0]:
- LOAD 0000011, JALR 1100111, OP-IMM 0010011 (funct3 ≠ 001/101): I format.
  - imm = sext(instr[31:20]).
- OP-IMM funct3 001/101: SHAMT format.
  - imm = zext(instr[24:20]) for XLEN=32, zext(instr[25:20]) for XLEN=64.
- OP-IMM-32 0011011: recognised only when XLEN=64.
  - funct3 001/101: SHAMT with instr[24:20].
  - Otherwise: I format.
  - When XLEN=32: illegal.
- STORE 0100011: S format.
  - imm = sext({instr[31:25], instr[11:7]}).
- BRANCH 1100011: B format.
  - imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- LUI 0110111, AUIPC 0010111: U format.
  - imm = sext({instr[31:12], 12'b0}); sign-extended to 64 when XLEN=64.
- JAL 1101111: J format.
  - imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- SYSTEM 1110011 with funct3[2]=1: ZIMM format.
  - imm = zext(instr[19:15]).
- SYSTEM with funct3[2]=0, OP 0110011, OP-32 0111011, FENCE 0001111: NONE format, imm = 0, legal.
- Any other opcode: NONE format, imm = 0, illegal = 1.

Buffering:
- Output register (primary) plus one skid entry.
- Input accepted when in_valid && in_ready; the entry is decoded before it is stored.
- Primary loads when it is empty or when out_ready is high. Otherwise the entry goes to the skid.
- When the primary drains and the skid is full, the skid moves to primary in that same cycle.
- in_ready = !skid_valid (registered).

Flush:
- Clears primary and skid valid.
- Any input presented in the same cycle is dropped; in_ready is ignored that cycle.

## Timing
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, skid empty, in_ready=1.
- Latency: an accept in cycle N with the stage empty gives out_valid=1 in cycle N+1.
- Throughput: 1 entry/cycle while out_ready=1.
- Back-pressure with out_ready=0:
  - The first accept fills primary.
  - The second accept fills the skid.
  - in_ready falls in the next cycle; no entry is lost.
- Simultaneous events:
  - Accept plus drain with the skid empty: primary replaced, throughput maintained.
  - Accept plus drain with the skid full: cannot occur, because in_ready=0.
- Ordering: strictly FIFO.
- out_* are stable while out_valid && !out_ready.
- Flush in cycle N: out_valid=0 and in_ready=1 from N+1.
- Reset mid-stream: all outputs return to their reset values immediately (asynchronously); entries in flight are discarded.

## Structure
- imm_pkg holds:
  - opcode localparams;
  - fmt codes;
  - an XLEN-legality check, with an elaboration error for values other than 32/64.
- Sub-module imm_extract:
  - purely combinational, instr → {imm, fmt, illegal};
  - parametrised by XLEN.
- imm_gen_stage instantiates imm_extract and holds the skid/handshake logic (~200 lines total).

## Test plan
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) → next cycle out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- Push 0x00112623 (sw x1,12(x2)) → imm=0x0000000C, fmt=2.
- Push 0xFE000CE3 (beq -8) → imm=0xFFFFFFF8, fmt=3.
- Push 0x123452B7 (lui) → imm=0x12345000, fmt=4.
- Push 0x001000EF (jal 2048) → imm=0x00000800, fmt=5.
- Push 0x0000007F → fmt=0, illegal=1, imm=0.
- XLEN=64:
  - Push 0x800002B7 → imm=0xFFFFFFFF80000000.
  - Push 0x03F0D093 (srli x1,x1,63) → imm=0x3F, fmt=6.
- out_ready=0, push tags 1,2,3:
  - tags 1 and 2 are accepted;
  - in_ready=0 from the cycle after the second accept;
  - tag 3 is held upstream;
  - after raising out_ready, tags 1,2,3 emerge in consecutive cycles.
- Flush with both entries full while in_valid=1 → out_valid=0 and in_ready=1 next cycle; the flushed-cycle input is never output.
- Assert reset while out_valid=1 → all outputs zero immediately; after deassert, first push appears with 1-cycle latency.
